// File: rtl/pipe_credit_queue.sv
// Receive-side circular queue behind a valid-only pipe: ready/valid dequeue, credit return, drop flag.
// Optional drop statistics counter enabled by PIPE_CREDIT_QUEUE_STATS_EN.
module pipe_credit_queue #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_enq_valid,
   input  logic [WIDTH-1:0] io_enq_bits,
   input  logic             io_deq_ready,
   output logic             io_deq_valid,
   output logic [WIDTH-1:0] io_deq_bits,
   output logic             io_credit,
   output logic [CW-1:0]    io_count,
`ifdef PIPE_CREDIT_QUEUE_STATS_EN
   output logic [7:0]       io_drop_count,
`endif
   output logic             io_overflow,
   input  logic             io_clear_overflow
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head, tail, head_nxt, tail_nxt;
   logic [CW-1:0]    count, count_nxt;
   logic             overflow, overflow_nxt;
   logic             credit;
   logic             full, empty, deq, enq, drop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign deq   = !empty && io_deq_ready;
   assign enq   = io_enq_valid && (!full || deq);
   assign drop  = io_enq_valid && full && !deq;

   // Pointer/occupancy next-state; a drop leaves everything untouched.
   always_comb begin
      head_nxt     = head;
      tail_nxt     = tail;
      count_nxt    = count;
      overflow_nxt = overflow;
      if (deq) head_nxt = (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
      if (enq) tail_nxt = (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
      case ({enq, deq})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
      if (drop) overflow_nxt = 1'b1;
      else if (io_clear_overflow) overflow_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         credit   <= 1'b0;
      end else begin
         head     <= head_nxt;
         tail     <= tail_nxt;
         count    <= count_nxt;
         overflow <= overflow_nxt;
         credit   <= deq;
      end
   end

   // Storage needs no reset; occupancy gates its visibility.
   always_ff @(posedge clk) begin
      if (enq) mem[tail] <= io_enq_bits;
   end

`ifdef PIPE_CREDIT_QUEUE_STATS_EN
   logic [7:0] drop_count, drop_count_nxt;

   // Clear has priority over increment, but a drop in the clear cycle counts as one.
   always_comb begin
      drop_count_nxt = drop_count;
      if (io_clear_overflow) drop_count_nxt = drop ? 8'd1 : 8'd0;
      else if (drop && drop_count != 8'hFF) drop_count_nxt = drop_count + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_count <= '0;
      else        drop_count <= drop_count_nxt;
   end

   assign io_drop_count = drop_count;
`endif

   assign io_deq_valid = !empty;
   assign io_deq_bits  = mem[head];
   assign io_count     = count;
   assign io_overflow  = overflow;
   assign io_credit    = credit;

endmodule

// File: tb/tb_pipe_credit_queue.sv
// Bench for pipe_credit_queue: vector table plus queue-based reference model and hand sequences.
module tb_pipe_credit_queue;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             io_enq_valid;
   logic [WIDTH-1:0] io_enq_bits;
   logic             io_deq_ready;
   logic             io_deq_valid;
   logic [WIDTH-1:0] io_deq_bits;
   logic             io_credit;
   logic [CW-1:0]    io_count;
   logic             io_overflow;
   logic             io_clear_overflow;
`ifdef PIPE_CREDIT_QUEUE_STATS_EN
   logic [7:0]       io_drop_count;
`endif

   always #5 clk = ~clk;

   pipe_credit_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .io_enq_valid      (io_enq_valid),
      .io_enq_bits       (io_enq_bits),
      .io_deq_ready      (io_deq_ready),
      .io_deq_valid      (io_deq_valid),
      .io_deq_bits       (io_deq_bits),
      .io_credit         (io_credit),
      .io_count          (io_count),
`ifdef PIPE_CREDIT_QUEUE_STATS_EN
      .io_drop_count     (io_drop_count),
`endif
      .io_overflow       (io_overflow),
      .io_clear_overflow (io_clear_overflow)
   );

   typedef struct {
      logic       ev;
      logic [7:0] b;
      logic       rdy;
      logic       clr;
      int         cnt;
      logic       vld;
      logic [7:0] bits;
      logic       cr;
      logic       ovf;
      int         drops;
   } vec_t;

   int         nerr = 0;
   int         nchk = 0;
   logic [7:0] q[$];
   logic       exp_credit = 1'b0;
   logic       exp_ovf    = 1'b0;
   int         exp_drops  = 0;
   vec_t       tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model predicts head/count before the edge and flags after it.
   task automatic cycle(input logic ev, input logic [7:0] b, input logic rdy, input logic clr);
      logic deq, enq, drop;
      io_enq_valid      = ev;
      io_enq_bits       = b;
      io_deq_ready      = rdy;
      io_clear_overflow = clr;
      #1;
      chk("deq_valid", 32'(io_deq_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("deq_bits", 32'(io_deq_bits), 32'(q[0]));
      chk("count", 32'(io_count), 32'(q.size()));
      deq  = (q.size() != 0) && rdy;
      enq  = ev && ((q.size() < int'(DEPTH)) || deq);
      drop = ev && !enq;
      @(posedge clk);
      #1;
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(b);
      exp_credit = deq;
      if (drop) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
      if (clr) exp_drops = drop ? 1 : 0;
      else if (drop && exp_drops != 255) exp_drops++;
      chk("credit", 32'(io_credit), 32'(exp_credit));
      chk("overflow", 32'(io_overflow), 32'(exp_ovf));
`ifdef PIPE_CREDIT_QUEUE_STATS_EN
      chk("drop_count", 32'(io_drop_count), 32'(exp_drops));
`endif
   endtask

   initial begin
      reset             = 1'b0;
      io_enq_valid      = 1'b0;
      io_enq_bits       = '0;
      io_deq_ready      = 1'b0;
      io_clear_overflow = 1'b0;

      //          ev    b      rdy   clr   cnt vld   bits   cr    ovf   drops
      tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
      tbl[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b1, 8'h01, 1'b0, 1'b0, 0};
      tbl[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b1, 8'h01, 1'b0, 1'b0, 0};
      tbl[5]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b1, 8'h01, 1'b0, 1'b0, 0};
      tbl[6]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b1, 8'h01, 1'b0, 1'b0, 0};
      tbl[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1, 8'h01, 1'b0, 1'b1, 1};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'h02, 1'b1, 1'b1, 1};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h03, 1'b1, 1'b1, 1};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h04, 1'b1, 1'b1, 1};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1, 1};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 0};

      // Reset state while held, then 10 idle cycles.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_deq_valid", 32'(io_deq_valid), 32'd0);
      chk("rst_count", 32'(io_count), 32'd0);
      chk("rst_credit", 32'(io_credit), 32'd0);
      chk("rst_overflow", 32'(io_overflow), 32'd0);
      reset = 1'b1;
      repeat (10) cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // Vector table: single beat, fill/drop, drain, clear.
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].ev, tbl[i].b, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("tbl%0d_count", i), 32'(io_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_valid", i), 32'(io_deq_valid), 32'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("tbl%0d_bits", i), 32'(io_deq_bits), 32'(tbl[i].bits));
         chk($sformatf("tbl%0d_credit", i), 32'(io_credit), 32'(tbl[i].cr));
         chk($sformatf("tbl%0d_ovf", i), 32'(io_overflow), 32'(tbl[i].ovf));
`ifdef PIPE_CREDIT_QUEUE_STATS_EN
         chk($sformatf("tbl%0d_drops", i), 32'(io_drop_count), 32'(tbl[i].drops));
`endif
      end

      // Full with simultaneous enq and deq: no drop, 8'h10 behind the older three.
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'h10, 1'b1, 1'b0);
      chk("full_pass_count", 32'(io_count), 32'd4);
      chk("full_pass_ovf", 32'(io_overflow), 32'd0);
      repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Fill 3 then stream 20 cycles: wrap, constant count, credit held high.
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
         chk("stream_count", 32'(io_count), 32'd3);
         chk("stream_credit", 32'(io_credit), 32'd1);
      end
      repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Drop together with clear: set wins; clear alone then clears.
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'h6F, 1'b0, 1'b1);
      chk("drop_clr_ovf", 32'(io_overflow), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_only_ovf", 32'(io_overflow), 32'd0);

`ifdef PIPE_CREDIT_QUEUE_STATS_EN
      // Drop counter saturation at 8'hFF.
      repeat (260) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("drops_sat", 32'(io_drop_count), 32'hFF);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
`endif
      repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset mid-stream with 2 entries and a credit pulse pending.
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", 32'(io_count), 32'd2);
      io_deq_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(io_deq_valid), 32'd0);
      chk("mid_rst_count", 32'(io_count), 32'd0);
      chk("mid_rst_credit", 32'(io_credit), 32'd0);
      chk("mid_rst_ovf", 32'(io_overflow), 32'd0);
      q.delete();
      exp_credit = 1'b0;
      exp_ovf    = 1'b0;
      exp_drops  = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h99, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/pipe_credit_queue.md
Name: pipe_credit_queue

Overview:
- Receive-side queue that sits directly downstream of the two-stage valid-only pipe.
- Captures the pipe's valid/bits stream, which has no backpressure, into a small circular buffer.
- Presents a ready/valid decoupled interface to the consumer.
- Returns one credit pulse per dequeued beat so the upstream sender can throttle to DEPTH beats in flight.
- A beat that arrives while the buffer is full is dropped and flagged.

Parameters:
WIDTH  8  data width of each beat
DEPTH  4  buffer entries; integer >= 2, need not be a power of two
CW     clog2(DEPTH+1)  width of the occupancy count (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
io_enq_valid  input  1  beat present from upstream pipe (no ready returned)
io_enq_bits  input  WIDTH  beat data
io_deq_ready  input  1  consumer can accept
io_deq_valid  output  1  head entry valid
io_deq_bits  output  WIDTH  head entry data
io_credit  output  1  one-cycle pulse, one per dequeued beat
io_count  output  CW  current occupancy, 0..DEPTH
io_overflow  output  1  sticky: a beat was dropped
io_clear_overflow  input  1  synchronous clear of io_overflow

Behaviour:
- Reset (asynchronous, while reset==0):
  - head = tail = count = 0.
  - io_deq_valid = 0, io_credit = 0, io_overflow = 0, io_count = 0.
  - Storage contents are don't-care.
- Occupancy and output:
  - full = (count == DEPTH); empty = (count == 0).
  - io_deq_valid = !empty; io_deq_bits = mem[head]; both driven combinationally from registers.
- Dequeue fire: deq = io_deq_valid && io_deq_ready. On fire, head advances (DEPTH-1 wraps to 0) and count decrements.
- Enqueue:
  - enq = io_enq_valid && (!full || deq).
  - On enq: mem[tail] <= io_enq_bits; tail advances with wrap; count increments.
  - Enq and deq in the same cycle leave count unchanged and both pointers advance.
- Full with deq in the same cycle: the incoming beat is accepted; no drop.
- No bypass: a beat enqueued into an empty queue becomes visible on io_deq_valid the next cycle. Minimum latency is 1 cycle.
- Drop: io_enq_valid && full && !deq. The beat is discarded; pointers and count are unchanged; io_overflow <= 1 at the next edge.
- io_overflow:
  - Cleared by io_clear_overflow at the clock edge.
  - If a drop and a clear occur in the same cycle, set wins and io_overflow stays 1.
- io_credit: registered; equals deq from the previous cycle. Exactly one pulse per dequeued beat, 1-cycle delay; back-to-back dequeues give a continuous high.
- Credit contract: the upstream sender starts with DEPTH credits after reset. In correct operation a drop never occurs; io_overflow exists for protocol debug.
- Reset mid-operation: all queued beats are discarded immediately; a credit pulse in flight is cancelled.
- io_deq_bits is stable while io_deq_valid && !io_deq_ready.

Optional Feature:
- Macro: PIPE_CREDIT_QUEUE_STATS_EN.
- Defined:
  - Adds output io_drop_count, 8 bits.
  - Increments on every drop cycle and saturates at 8'hFF.
  - Cleared to 0 by reset and by io_clear_overflow.
  - A drop and a clear in the same cycle produce 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → io_deq_valid=0, io_count=0, io_credit=0, io_overflow=0 for 10 cycles.
- Single beat 8'hA5 with io_deq_ready=1 → io_deq_valid=1 with bits 8'hA5 one cycle later; io_credit pulses on the following cycle; io_count returns to 0.
- io_deq_ready=0, enqueue 8'h01..8'h04 → io_count=4 (full); 5th beat 8'h05 dropped, io_overflow=1 (with stats: io_drop_count=1). Then drain → 01,02,03,04 in order, exactly 4 credit pulses.
- Full, io_deq_ready=1 and io_enq_valid=1 (8'h10) in the same cycle → no drop, io_count stays 4, 8'h10 emerges after the three older entries.
- Fill 3, enqueue and dequeue continuously for 20 cycles → pointers wrap (DEPTH=4), data order preserved, io_count constant at 3, io_credit held high.
- Drop and io_clear_overflow in the same cycle → io_overflow=1; a clear on the next cycle alone → io_overflow=0. Assert reset mid-stream with 2 entries → io_deq_valid=0, io_count=0 immediately.
